// File: rtl/tinytpu_mm_engine_if.sv
// Stream/handshake bundle between the matrix-multiply engine and its host.
// The master drives operands and flow control; the slave returns Z and status.
interface tinytpu_mm_engine_if #(
  parameter int LANES = 1
);
  logic [LANES-1:0] data_in_x;
  logic [LANES-1:0] data_in_y;
  logic             load_en;
  logic             init;
  logic             acc_mode;
  logic             rd_en;
  logic [LANES-1:0] data_out_z;
  logic             tx_ready;
  logic             busy;

  modport master (
    output data_in_x, data_in_y, load_en, init, acc_mode, rd_en,
    input  data_out_z, tx_ready, busy
  );

  modport slave (
    input  data_in_x, data_in_y, load_en, init, acc_mode, rd_en,
    output data_out_z, tx_ready, busy
  );
endinterface

// File: rtl/tinytpu_mm_engine.sv
// Bit-serial NxN signed matrix-multiply engine: Z = Z' + X*Y.
// Operands stream in LANES bits/cycle, an output-stationary systolic array computes Z.
module tinytpu_mm_engine #(
  parameter int D_W   = 8,
  parameter int N     = 2,
  parameter int LANES = 1
) (
  input logic                clk,
  input logic                rst,
  tinytpu_mm_engine_if.slave bus
);
  localparam int ACC_W    = 2 * D_W + $clog2(N);
  localparam int TX_W     = ((ACC_W + LANES - 1) / LANES) * LANES;
  localparam int L        = N * N * D_W / LANES;
  localparam int T        = N * N * TX_W / LANES;
  localparam int MAT_W    = N * N * D_W;
  localparam int TXS_W    = N * N * TX_W;
  localparam int CMP_LAST = 3 * N - 2;
  localparam int LD_CW    = $clog2(L + 1);
  localparam int CMP_CW   = $clog2(CMP_LAST + 1);
  localparam int TX_CW    = $clog2(T);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_TX} state_t;

  state_t                   state, state_next;
  logic [LD_CW-1:0]         ld_cnt;
  logic [CMP_CW-1:0]        cmp_cnt;
  logic [TX_CW-1:0]         tx_cnt;
  logic [MAT_W-1:0]         x_flat, y_flat;
  logic [TXS_W-1:0]         tx_sr, tx_pack;
  logic signed [D_W-1:0]    a_reg [N][N];
  logic signed [D_W-1:0]    b_reg [N][N];
  logic signed [D_W-1:0]    a_in  [N][N];
  logic signed [D_W-1:0]    b_in  [N][N];
  logic signed [2*D_W-1:0]  prod  [N][N];
  logic signed [ACC_W-1:0]  z     [N][N];
  logic                     ld_full, start, accept, tx_last;

  assign ld_full = (ld_cnt == LD_CW'(L));
  assign start   = (state == S_LOAD) && bus.init && ld_full;
  assign accept  = (state == S_TX) && bus.rd_en;
  assign tx_last = (tx_cnt == TX_CW'(T - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LOAD:    if (start) state_next = S_COMPUTE;
      S_COMPUTE: if (cmp_cnt == CMP_CW'(CMP_LAST)) state_next = S_TX;
      S_TX:      if (accept && tx_last) state_next = S_LOAD;
      default:   state_next = S_LOAD;
    endcase
  end

  // Edge feeders skew the operands: row i / column j sees element k at step i+k / j+k,
  // so PE(i,j) multiplies x[i][k]*y[k][j] at step i+j+k.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_in[i][j] = '0;
        b_in[i][j] = '0;
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (int'(cmp_cnt) == i + k) begin
          a_in[i][0] = x_flat[(i*N+k)*D_W +: D_W];
          b_in[0][i] = y_flat[(k*N+i)*D_W +: D_W];
        end
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 1; j < N; j++)
        a_in[i][j] = a_reg[i][j-1];
    for (int i = 1; i < N; i++)
      for (int j = 0; j < N; j++)
        b_in[i][j] = b_reg[i-1][j];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        prod[i][j] = a_in[i][j] * b_in[i][j];
  end

  always_comb begin
    tx_pack = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        tx_pack[(i*N+j)*TX_W +: TX_W] = TX_W'(z[i][j]);
  end

  // Datapath and registered outputs; status flags follow the next state so they
  // line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt         <= '0;
      cmp_cnt        <= '0;
      tx_cnt         <= '0;
      x_flat         <= '0;
      y_flat         <= '0;
      tx_sr          <= '0;
      bus.data_out_z <= '0;
      bus.tx_ready   <= 1'b0;
      bus.busy       <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          z[i][j]     <= '0;
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
        end
      end
    end else begin
      bus.tx_ready <= (state_next == S_TX);
      bus.busy     <= (state_next != S_LOAD);
      case (state)
        S_LOAD: begin
          if (start) begin
            cmp_cnt <= '0;
            for (int i = 0; i < N; i++) begin
              for (int j = 0; j < N; j++) begin
                a_reg[i][j] <= '0;
                b_reg[i][j] <= '0;
                if (!bus.acc_mode) z[i][j] <= '0;
              end
            end
          end else if (bus.load_en && !ld_full) begin
            x_flat <= {bus.data_in_x, x_flat[MAT_W-1:LANES]};
            y_flat <= {bus.data_in_y, y_flat[MAT_W-1:LANES]};
            ld_cnt <= ld_cnt + 1'b1;
          end
        end
        S_COMPUTE: begin
          if (cmp_cnt == CMP_CW'(CMP_LAST)) begin
            tx_sr          <= tx_pack;
            bus.data_out_z <= tx_pack[LANES-1:0];
            tx_cnt         <= '0;
          end else begin
            for (int i = 0; i < N; i++) begin
              for (int j = 0; j < N; j++) begin
                a_reg[i][j] <= a_in[i][j];
                b_reg[i][j] <= b_in[i][j];
                z[i][j]     <= z[i][j] + ACC_W'(prod[i][j]);
              end
            end
            cmp_cnt <= cmp_cnt + 1'b1;
          end
        end
        S_TX: begin
          if (accept) begin
            if (tx_last) begin
              ld_cnt         <= '0;
              bus.data_out_z <= '0;
            end else begin
              tx_sr          <= tx_sr >> LANES;
              bus.data_out_z <= tx_sr[2*LANES-1:LANES];
              tx_cnt         <= tx_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
